uart_rx_top: RTL and testbench

Asynchronous serial receiver that pairs with the team's UART transmitter. It deserialises 8N1, 8O1 and 8E1 frames from the `rx` line into parallel bytes, using 16x oversampling. Baud-rate and parity encodings are the same as the transmitter's, so one control register drives both ends. The block sits between the board RX pin and the byte-consuming logic, and reports each byte with a one-cycle `done` strobe plus error flags.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_top.sv | 121 ++++++++++++
 tb/tb_uart_rx_top.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state, baud/parity codes and divisor helper shared by the UART receiver and transmitter.
package uart_pkg;

   localparam int OVERSAMPLE     = 16;
   localparam int DEFAULT_CLK_HZ = 50_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam logic [1:0] BAUD_2400  = 2'b00;
   localparam logic [1:0] BAUD_4800  = 2'b01;
   localparam logic [1:0] BAUD_9600  = 2'b10;
   localparam logic [1:0] BAUD_19200 = 2'b11;

   localparam logic [1:0] PAR_NONE     = 2'b00;
   localparam logic [1:0] PAR_ODD      = 2'b01;
   localparam logic [1:0] PAR_EVEN     = 2'b10;
   localparam logic [1:0] PAR_NONE_ALT = 2'b11;

   function automatic int baud_of(input logic [1:0] code);
      return code == BAUD_2400 ? 2400 : code == BAUD_4800 ? 4800 : code == BAUD_9600 ? 9600 : 19200;
   endfunction

   // Per-code tick divisor, rounded to nearest (1302/651/326/163 at 50 MHz).
   function automatic int baud_div(input int clk_hz, input logic [1:0] code);
      return (clk_hz + baud_of(code) * OVERSAMPLE / 2) / (baud_of(code) * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: single-cycle 16x oversampling tick for the selected baud code; clear restarts the period.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [1:0] baud_rate,
   output logic       tick
);

   localparam logic [15:0] DIV_TAB [4] = '{
      16'(baud_div(CLK_HZ, BAUD_2400)),
      16'(baud_div(CLK_HZ, BAUD_4800)),
      16'(baud_div(CLK_HZ, BAUD_9600)),
      16'(baud_div(CLK_HZ, BAUD_19200))
   };

   logic [15:0] cnt;

   assign tick = !clear && cnt == DIV_TAB[baud_rate] - 16'd1;

   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else cnt <= (clear || tick) ? '0 : cnt + 16'd1;

endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top: 16x-oversampled 8N1/8O1/8E1 UART receiver with done strobe and error flags.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote over ticks 6, 7 and 8.
module uart_rx_top
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = DEFAULT_CLK_HZ,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] baud_rate,
   input  logic [1:0] parity_type,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       done,
   output logic       receiving,
   output logic       parity_error,
   output logic       framing_error
);

   localparam logic [3:0] MID = 4'(OVERSAMPLE / 2);

   uart_state_t state_q, state_d;
   logic       rx_meta, rx_s, rx_prev;
   logic [1:0] baud_q, par_q;
   logic       tick;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic       s_mid, par_bit, wait_high, bit_val;
   logic       fall, start_det, sample, finish, par_en, perr_calc;

   assign fall      = rx_prev & ~rx_s;
   assign start_det = state_q == ST_IDLE && enable && fall && !wait_high;
   // Every bit is decided one tick after its nominal mid-point so both sampling modes share timing.
   assign sample    = tick && tick_cnt == MID;
   assign finish    = state_q == ST_STOP && enable && sample;
   assign par_en    = !(par_q inside {PAR_NONE, PAR_NONE_ALT});
   assign perr_calc = par_en && ((^shift ^ par_bit) != (par_q == PAR_ODD));
   assign receiving = state_q != ST_IDLE;

   uart_baud_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_det),
      .baud_rate (baud_q),
      .tick      (tick)
   );

`ifdef UART_RX_MAJORITY_EN
   logic s_early;
   always_ff @(posedge clk or negedge reset)
      if (!reset) s_early <= 1'b1;
      else if (tick && tick_cnt == MID - 4'd2) s_early <= rx_s;
   assign bit_val = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
   assign bit_val = s_mid;
`endif

   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= ST_IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = start_det ? ST_START : ST_IDLE;
         ST_START:  if (sample) state_d = bit_val ? ST_IDLE : ST_DATA;
         ST_DATA:   if (sample && bit_cnt == 3'd7) state_d = par_en ? ST_PARITY : ST_STOP;
         ST_PARITY: if (sample) state_d = ST_STOP;
         ST_STOP:   if (sample) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (!enable) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_meta       <= 1'b1;
         rx_s          <= 1'b1;
         rx_prev       <= 1'b1;
         baud_q        <= BAUD_2400;
         par_q         <= PAR_NONE;
         tick_cnt      <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         s_mid         <= 1'b1;
         par_bit       <= 1'b0;
         wait_high     <= 1'b0;
         dout          <= '0;
         done          <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
         done    <= finish;
         if (start_det) begin
            baud_q   <= baud_rate;
            par_q    <= parity_type;
            tick_cnt <= '0;
            bit_cnt  <= '0;
         end else if (tick) tick_cnt <= tick_cnt + 4'd1;
         if (tick && tick_cnt == MID - 4'd1) s_mid <= rx_s;
         if (state_q == ST_DATA && sample) begin
            shift   <= {bit_val, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (state_q == ST_PARITY && sample) par_bit <= bit_val;
         if (finish) begin
            dout          <= shift;
            parity_error  <= perr_calc;
            framing_error <= ~bit_val;
         end
         // A low stop bit blocks re-arming until the line has been seen high again.
         wait_high <= finish ? ~bit_val : wait_high & ~rx_s;
      end

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed frames against a queue-based expected-result model with per-cycle output checks.
`timescale 1ns/1ps
module tb_uart_rx_top;

   localparam int CLK_HZ = 1_000_000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] baud_rate = 2'b00;
   logic [1:0] parity_type = 2'b00;
   logic       rx = 1'b1;
   logic [7:0] dout;
   logic       done, receiving, parity_error, framing_error;

   always #500 clk = ~clk;

   uart_rx_top #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .baud_rate     (baud_rate),
      .parity_type   (parity_type),
      .rx            (rx),
      .dout          (dout),
      .done          (done),
      .receiving     (receiving),
      .parity_error  (parity_error),
      .framing_error (framing_error)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       f;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         total = 0;
   int         bad = 0;
   int         n_done = 0;
   int         base = 0;
   logic [7:0] m_dout = 8'h00;
   logic       m_perr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       prev_done = 1'b0;
   logic [7:0] snap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bit_cycles(input logic [1:0] b);
      int baud = 2400 << b;
      return 16 * ((CLK_HZ + baud * 8) / (baud * 16));
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #100;
   endtask

   // abort: 0 = complete frame, 1 = reset pulse in data bit 4, 2 = enable dropped from data bit 4 on.
   task automatic send(input logic [7:0] d, input logic bad_par, input logic stop, input int abort);
      int          bl = bit_cycles(baud_rate);
      logic        pe = parity_type == 2'b01 || parity_type == 2'b10;
      logic        pb = (parity_type == 2'b01) ? ~^d : ^d;
      logic [10:0] line;
      int          n;
      if (bad_par) pb = ~pb;
      line = pe ? {stop, pb, d, 1'b0} : {1'b0, stop, d, 1'b0};
      n = pe ? 11 : 10;
      if (abort == 0) q.push_back('{d: d, p: pe && ((^d ^ pb) != (parity_type == 2'b01)), f: ~stop});
      for (int i = 0; i < n; i++) begin
         rx = line[i];
         if (i == 5 && abort != 0) begin
            cyc(bl / 2);
            if (abort == 1) begin
               reset = 1'b0;
               cyc(3);
               reset = 1'b1;
               cyc(bl - bl / 2 - 3);
            end else begin
               enable = 1'b0;
               cyc(3);
               chk("enable_abort_idle", receiving, 0);
               cyc(bl - bl / 2 - 3);
            end
         end else cyc(bl);
      end
      if (abort == 2) enable = 1'b1;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (q.size() != 0 && k < 5000) begin
         cyc(1);
         k++;
      end
      chk(name, q.size(), 0);
      q.delete();
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         m_dout = 8'h00;
         m_perr = 1'b0;
         m_ferr = 1'b0;
         q.delete();
         chk("reset_outputs", {dout, done, receiving, parity_error, framing_error}, 0);
      end else begin
         if (done) begin
            n_done++;
            chk("done_expected", q.size() > 0, 1);
            chk("done_width", prev_done, 0);
            if (q.size() > 0) begin
               e = q.pop_front();
               m_dout = e.d;
               m_perr = e.p;
               m_ferr = e.f;
            end
         end
         chk("dout", dout, m_dout);
         chk("parity_error", parity_error, m_perr);
         chk("framing_error", framing_error, m_ferr);
      end
      prev_done = done;
   end

   initial begin
      #100ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      cyc(5);
      reset = 1'b1;
      cyc(2);
      chk("idle_receiving", receiving, 0);
      enable = 1'b1;
      cyc(2);

      baud_rate = 2'b10; parity_type = 2'b00; base = n_done;
      send(8'hA5, 1'b0, 1'b1, 0);
      drain("a5_drain");
      chk("a5_dout", dout, 8'hA5);
      chk("a5_flags", {parity_error, framing_error}, 0);
      chk("a5_count", n_done - base, 1);

      baud_rate = 2'b00; parity_type = 2'b01;
      send(8'h3C, 1'b0, 1'b1, 0);
      drain("odd_ok_drain");
      chk("odd_ok_dout", dout, 8'h3C);
      chk("odd_ok_perr", parity_error, 0);
      send(8'h3C, 1'b1, 1'b1, 0);
      drain("odd_bad_drain");
      chk("odd_bad_perr", parity_error, 1);

      baud_rate = 2'b11; parity_type = 2'b10; base = n_done;
      send(8'h00, 1'b0, 1'b1, 0);
      send(8'hFF, 1'b0, 1'b1, 0);
      drain("b2b_drain");
      chk("b2b_count", n_done - base, 2);
      chk("b2b_dout", dout, 8'hFF);
      chk("b2b_flags", {parity_error, framing_error}, 0);

      baud_rate = 2'b10; parity_type = 2'b00; base = n_done; snap = dout;
      rx = 1'b0;
      cyc(4);
      rx = 1'b1;
      k = 0;
      while (!receiving && k < 20) begin cyc(1); k++; end
      chk("glitch_receiving_rise", receiving, 1);
      k = 0;
      while (receiving && k < 3 * bit_cycles(2'b10)) begin cyc(1); k++; end
      chk("glitch_receiving_fall", receiving, 0);
      chk("glitch_no_done", n_done - base, 0);
      chk("glitch_dout", dout, snap);

      base = n_done;
      send(8'h55, 1'b0, 1'b0, 0);
      cyc(30 * bit_cycles(2'b10));
      chk("break_count", n_done - base, 1);
      chk("break_ferr", framing_error, 1);
      chk("break_dout", dout, 8'h55);
      rx = 1'b1;
      cyc(bit_cycles(2'b10));
      send(8'h12, 1'b0, 1'b1, 0);
      drain("after_break_drain");
      chk("after_break_dout", dout, 8'h12);
      chk("after_break_ferr", framing_error, 0);

      base = n_done;
      send(8'hF0, 1'b0, 1'b1, 1);
      cyc(bit_cycles(2'b10));
      chk("reset_abort_no_done", n_done - base, 0);
      chk("reset_abort_dout", dout, 8'h00);
      send(8'h81, 1'b0, 1'b1, 0);
      drain("after_reset_drain");
      chk("after_reset_dout", dout, 8'h81);

      base = n_done;
      send(8'hF0, 1'b0, 1'b1, 2);
      cyc(bit_cycles(2'b10));
      chk("enable_abort_no_done", n_done - base, 0);
      chk("enable_abort_dout", dout, 8'h81);
      send(8'hC3, 1'b0, 1'b1, 0);
      drain("after_enable_drain");
      chk("after_enable_dout", dout, 8'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
